// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access unit.
//   size_e  : request access size encoding (ReqSize)
//   state_e : access FSM states
//   ZERO_WORD_IDX : word index that is hardwired to zero and read-only
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  localparam int ZERO_WORD_IDX = 0;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data-memory access unit.
// Ports:
//   word_i    : memory word (read data)
//   lane_i    : byte lane within the word (address bits 1:0), little-endian
//   size_i    : access size
//   signed_i  : 1 = sign-extend loads, 0 = zero-extend
//   wdata_i   : right-justified store data
//   ld_data_o : extracted and extended load result
//   st_word_o : word_i with the selected lane replaced by wdata_i
//               (wdata_i itself for word accesses)
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int AWIDTH = 32
) (
  input  logic [AWIDTH-1:0] word_i,
  input  logic [1:0]        lane_i,
  input  size_e             size_i,
  input  logic              signed_i,
  input  logic [AWIDTH-1:0] wdata_i,
  output logic [AWIDTH-1:0] ld_data_o,
  output logic [AWIDTH-1:0] st_word_o
);

  logic [4:0]        sh;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [AWIDTH-1:0] byte_mask;
  logic [AWIDTH-1:0] half_mask;
  logic [AWIDTH-1:0] byte_ins;
  logic [AWIDTH-1:0] half_ins;

  // Lane shift in bits; half accesses only reach here aligned (lane 0 or 2).
  assign sh        = {lane_i, 3'b000};
  assign byte_v    = 8'(word_i >> sh);
  assign half_v    = 16'(word_i >> sh);
  assign byte_mask = {{(AWIDTH-8){1'b0}}, 8'hFF} << sh;
  assign half_mask = {{(AWIDTH-16){1'b0}}, 16'hFFFF} << sh;
  assign byte_ins  = {{(AWIDTH-8){1'b0}}, wdata_i[7:0]} << sh;
  assign half_ins  = {{(AWIDTH-16){1'b0}}, wdata_i[15:0]} << sh;

  always_comb begin
    ld_data_o = word_i;
    st_word_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        ld_data_o = {{(AWIDTH-8){signed_i & byte_v[7]}}, byte_v};
        st_word_o = (word_i & ~byte_mask) | byte_ins;
      end
      SZ_HALF: begin
        ld_data_o = {{(AWIDTH-16){signed_i & half_v[15]}}, half_v};
        st_word_o = (word_i & ~half_mask) | half_ins;
      end
      default: begin
        ld_data_o = word_i;
        st_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store controller between the pipeline and the data memory.
// One request in flight at a time; sub-word stores use read-modify-write.
// Ports:
//   Clk, Rst_n        : clock, asynchronous active-low reset
//   ReqValid/ReqReady : request handshake
//   ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData : request fields
//   RespValid, RespData, RespErr : one-cycle response
//   MemWE, MemAddr, MemWData, MemRData : memory port (word-indexed)
//   DbgState          : current FSM state
// Handshake: a request transfers on a rising Clk edge where ReqValid and
// ReqReady are both high; all Req* fields are captured at that edge.
// ReqReady is high only in IDLE. RespValid is a single-cycle pulse that
// cannot be stalled; ReqReady returns the cycle after it.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int ALENGTH = 128
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [AWIDTH-1:0] ReqAddr,
  input  logic [AWIDTH-1:0] ReqWData,
  output logic              RespValid,
  output logic [AWIDTH-1:0] RespData,
  output logic              RespErr,
  output logic              MemWE,
  output logic [AWIDTH-1:0] MemAddr,
  output logic [AWIDTH-1:0] MemWData,
  input  logic [AWIDTH-1:0] MemRData,
  output logic [1:0]        DbgState
);

  localparam int IDXW = $clog2(ALENGTH);
  localparam logic [AWIDTH:0] ADDR_LIMIT = (AWIDTH+1)'(ALENGTH * 4);

  state_e            state_q;
  logic              ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [AWIDTH-1:0] resp_data_q;
  logic              mem_we_q;
  logic [IDXW-1:0]   mem_idx_q;
  logic [AWIDTH-1:0] mem_wdata_q;

  // Latched request fields
  logic              write_q;
  size_e             size_q;
  logic              signed_q;
  logic [1:0]        lane_q;
  logic [AWIDTH-1:0] wdata_q;

  size_e             req_size;
  logic [IDXW-1:0]   req_idx;
  logic              req_err;
  logic              accept;
  logic [AWIDTH-1:0] ld_data;
  logic [AWIDTH-1:0] st_word;

  assign req_size = size_e'(ReqSize);
  assign req_idx  = ReqAddr[IDXW+1:2];
  assign accept   = ReqValid && ready_q;

  // Only reachable from IDLE, where the request fields at the accept edge
  // are exactly what gets latched, so checking them directly is equivalent.
  assign req_err = (req_size == SZ_RSVD)
                || (req_size == SZ_HALF && ReqAddr[0])
                || (req_size == SZ_WORD && ReqAddr[1:0] != 2'b00)
                || ({1'b0, ReqAddr} >= ADDR_LIMIT)
                || (ReqWrite && req_idx == IDXW'(ZERO_WORD_IDX));

  dmem_lane_align #(.AWIDTH(AWIDTH)) u_lane_align (
    .word_i    (MemRData),
    .lane_i    (lane_q),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_idx_q    <= '0;
      mem_wdata_q  <= '0;
      write_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
    end else begin
      // Pulse outputs default low; the state that needs them reasserts.
      resp_valid_q <= 1'b0;
      mem_we_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            ready_q     <= 1'b0;
            write_q     <= ReqWrite;
            size_q      <= req_size;
            signed_q    <= ReqSigned;
            lane_q      <= ReqAddr[1:0];
            wdata_q     <= ReqWData;
            resp_data_q <= '0;
            if (req_err) begin
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              resp_err_q <= 1'b0;
              mem_idx_q  <= req_idx;
              if (ReqWrite && req_size == SZ_WORD) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= ReqWData;
                state_q     <= WR;
              end else begin
                state_q <= RD;
              end
            end
          end else begin
            // Also provides the first-edge-after-reset rise of ReqReady.
            ready_q <= 1'b1;
          end
        end
        RD: begin
          if (write_q) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= st_word;
            state_q     <= WR;
          end else begin
            resp_data_q  <= ld_data;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_err_q  <= 1'b0;
          resp_data_q <= '0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ReqReady  = ready_q;
  assign RespValid = resp_valid_q;
  assign RespErr   = resp_err_q;
  assign RespData  = resp_data_q;
  assign MemWE     = mem_we_q;
  assign MemAddr   = AWIDTH'(mem_idx_q);
  assign MemWData  = mem_wdata_q;
  assign DbgState  = state_q;

endmodule
